// File: rtl/decoder_3to8_strobe_pkg.sv
// Shared definitions for the 3-to-8 strobe decoder and its companion encoder.
package decoder_pkg;

    // Code and line widths shared with the 8-to-3 one-hot encoder block.
    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_3to8.sv
// Purely combinational 3-bit code to one-hot 8-bit line decoder.
module decoder_3to8
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [LINES-1:0]  onehot_o
);

    // Exactly one line set, at the position named by the code.
    always_comb begin
        onehot_o         = '0;
        onehot_o[code_i] = 1'b1;
    end

endmodule

// File: rtl/decoder_3to8_strobe.sv
// Sequenced 3-to-8 decoder: accepts a code over valid/ready, holds the
// matching one-hot line for HOLD_CYCLES, then forces GAP_CYCLES of idle.
module decoder_3to8_strobe
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CODE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [LINES-1:0]  dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $fatal(1, "decoder_3to8_strobe: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_chk_gap
        $fatal(1, "decoder_3to8_strobe: GAP_CYCLES must be >= 0");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [LINES-1:0]   dout_q,  dout_d;
    logic [LINES-1:0]   line_dec;

    decoder_3to8 u_core (
        .code_i   (din),
        .onehot_o (line_dec)
    );

    // State, counter and output line registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state, counter reload/decrement, handshake and done decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        din_ready = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                din_ready = en;
                if (din_valid && en) begin
                    dout_d  = line_dec;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (HAS_GAP) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    dout_d  = '0;
                end else begin
                    state_d = IDLE;
                    dout_d  = '0;
                    done    = 1'b1;
                end
            end
            GAP: begin
                dout_d = '0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dout_d  = '0;
            end
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == HOLD);
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/decoder_3to8_strobe.md
# decoder_3to8_strobe

Sequenced 3-to-8 decoder: the companion to the team's 8-to-3 one-hot encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line on an 8-bit registered output for a programmable hold time. It then forces a programmable idle gap before accepting the next code. It drives one-hot select/strobe lines such as chip selects, mux selects and interrupt lines, whose encoded form the existing encoder consumes.

## Interface
- HOLD_CYCLES, default 4: cycles the one-hot line stays asserted; legal range ≥1.
- GAP_CYCLES, default 1: cycles of all-zero output after the hold; legal range ≥0.
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  acceptance enable; gates only new acceptances.
- din  input  3  code to decode.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept a code this cycle.
- dout  output  8  registered one-hot output; all zero when not holding.
- dout_valid  output  1  high exactly while dout is non-zero (HOLD state).
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse on the last cycle of a transaction.

## Operation
- FSM states are IDLE, HOLD and GAP. A down-counter cnt has width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
- IDLE: din_ready = en. Acceptance occurs when din_valid && din_ready at an edge. At that edge:
  - the code is captured;
  - dout <= 8'b1 << din;
  - the state goes to HOLD;
  - cnt <= HOLD_CYCLES-1.
- HOLD:
  - dout is held and din_ready = 0.
  - While cnt != 0, cnt decrements.
  - When cnt == 0 and GAP_CYCLES > 0: next state is GAP, cnt <= GAP_CYCLES-1, and dout <= 0.
  - When cnt == 0 and GAP_CYCLES == 0: next state is IDLE and dout <= 0.
- GAP:
  - dout = 0 and din_ready = 0.
  - cnt decrements; when cnt == 0, next state is IDLE.
- done = 1 in the last HOLD cycle when GAP_CYCLES == 0, otherwise in the last GAP cycle. It is a combinational decode of state and cnt.
- busy = (state != IDLE). dout_valid = (state == HOLD).
- din and din_valid are ignored outside IDLE. din changing mid-transaction has no effect on dout.
- Deasserting en mid-transaction does not abort the transaction; it only blocks the next acceptance.
- Every 3-bit value is legal; there is no error or illegal-code path.
- dout is always either zero or exactly one-hot (popcount ≤ 1) in every cycle.
- Reset: on any edge with rst = 1, the following apply regardless of state:
  - state <= IDLE, cnt <= 0, dout <= 0;
  - dout_valid, busy and done are 0 the following cycle;
  - din_ready = en from that cycle.
- Reset mid-HOLD or mid-GAP aborts the transaction without a done pulse.

## Timing
- Acceptance at edge N: dout is one-hot from cycle N+1 through N+HOLD_CYCLES inclusive.
- dout is zero for cycles N+HOLD_CYCLES+1 through N+HOLD_CYCLES+GAP_CYCLES.
- din_ready is back high (if en) at cycle N+HOLD_CYCLES+GAP_CYCLES+1.
- Minimum spacing between acceptances is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- No back-to-back acceptance even with GAP_CYCLES = 0; IDLE is always visited for at least one cycle.
- din_ready is combinational from state and en; there is no combinational path from din_valid to din_ready.
- dout and dout_valid change only on clock edges. There are no glitches on dout because it is driven directly from a register.

## Structure
- Shared package decoder_pkg holds:
  - the state enum (IDLE, HOLD, GAP);
  - localparams CODE_W = 3 and LINES = 8, shared with the encoder block.
- One natural sub-module, decoder_3to8: a purely combinational 3-bit to one-hot 8-bit core. The top instantiates it and registers its output into dout.
- Parameter checks at elaboration: HOLD_CYCLES ≥ 1 and GAP_CYCLES ≥ 0. A violation is a fatal error.

## Test plan
- Reset: assert rst for 2 cycles with en = 1. Required next cycle: dout = 8'h00, dout_valid = 0, busy = 0, done = 0, din_ready = 1.
- Single decode (HOLD_CYCLES = 4, GAP_CYCLES = 1): din = 3'd5 accepted at edge N. Required:
  - dout = 8'b0010_0000 and dout_valid = 1 in cycles N+1 through N+4;
  - dout = 0 and done = 1 in cycle N+5;
  - din_ready = 1 in cycle N+6.
- Sweep: din_valid held high while din steps through 0..7 after each acceptance. Required:
  - each hold shows exactly one bit set, at position din;
  - feeding dout through the encoder returns din;
  - acceptances are exactly 6 cycles apart.
- Interference: change din to 3'd2 during HOLD of code 3'd6. Required: dout stays 8'b0100_0000 for the full hold. With en = 0 and din_valid = 1 in IDLE, no acceptance and dout stays 0.
- Abort: rst asserted in the second HOLD cycle of code 3'd1. Required: the next cycle has dout = 0, busy = 0, no done pulse, and the block is in IDLE.
- GAP_CYCLES = 0 instance: code 3'd7 accepted at edge N. Required:
  - dout = 8'h80 in cycles N+1 through N+4, with done = 1 in cycle N+4;
  - dout = 0 and din_ready = 1 in cycle N+5.
